// File: rtl/perf_counter_bank_if.sv
// Event, control and read-back signals of perf_counter_bank, grouped for the
// CPU event side (master) and the counter bank itself (slave).
interface perf_counter_bank_if #(
   parameter int NUM_CH = 7,
   parameter int CNT_W  = 32
);
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // "event" is a reserved word, so the increment strobes are named evt.
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] evt;
   logic              clear;
   logic              halt;
   logic              snap;
   logic [SEL_W-1:0]  rd_sel;
   logic              rd_shadow;
   logic [CNT_W-1:0]  rd_data;
   logic [NUM_CH-1:0] ovf;
   logic              frozen;

   modport master (
      output ch_en, evt, clear, halt, snap, rd_sel, rd_shadow,
      input  rd_data, ovf, frozen
   );

   modport slave (
      input  ch_en, evt, clear, halt, snap, rd_sel, rd_shadow,
      output rd_data, ovf, frozen
   );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with sticky overflow, halt freeze, atomic
// snapshot into shadow registers and a registered indexed read port.
module perf_counter_bank #(
   parameter int NUM_CH   = 7,
   parameter int CNT_W    = 32,
   parameter int SATURATE = 0
) (
   input  logic               clk,
   input  logic               rst,
   perf_counter_bank_if.slave bus
);
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   // Read table is padded to a power of two so out-of-range selects hit zero slots.
   localparam int N_SLOT = 1 << SEL_W;

   logic [CNT_W-1:0]  cnt_all    [N_SLOT];
   logic [CNT_W-1:0]  shadow_all [N_SLOT];
   logic [NUM_CH-1:0] ovf_all;

   logic              frozen_q;
   logic              frozen_d;
   logic [CNT_W-1:0]  rd_data_q;
   logic [CNT_W-1:0]  rd_data_d;

   genvar gi;
   generate
      for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
         if (gi < NUM_CH) begin : g_ch
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic [CNT_W-1:0] shadow_q;
            logic [CNT_W-1:0] shadow_d;
            logic             ovf_q;
            logic             ovf_d;
            logic             inc;

            always_comb begin
               inc      = bus.evt[gi] & bus.ch_en[gi] & ~frozen_q & ~bus.clear;
               cnt_d    = cnt_q;
               ovf_d    = ovf_q;
               // Shadow takes the pre-edge value, so a same-edge increment is excluded.
               shadow_d = bus.snap ? cnt_q : shadow_q;
               if (bus.clear) begin
                  cnt_d = '0;
                  ovf_d = 1'b0;
               end else if (inc) begin
                  if (&cnt_q) begin
                     ovf_d = 1'b1;
                     cnt_d = (SATURATE != 0) ? cnt_q : '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  cnt_q    <= '0;
                  shadow_q <= '0;
                  ovf_q    <= 1'b0;
               end else begin
                  cnt_q    <= cnt_d;
                  shadow_q <= shadow_d;
                  ovf_q    <= ovf_d;
               end
            end

            assign cnt_all[gi]    = cnt_q;
            assign shadow_all[gi] = shadow_q;
            assign ovf_all[gi]    = ovf_q;
         end else begin : g_pad
            assign cnt_all[gi]    = '0;
            assign shadow_all[gi] = '0;
         end
      end
   endgenerate

   always_comb begin
      frozen_d = frozen_q;
      if (bus.clear) begin
         frozen_d = 1'b0;
      end else if (bus.halt) begin
         frozen_d = 1'b1;
      end
      rd_data_d = bus.rd_shadow ? shadow_all[bus.rd_sel] : cnt_all[bus.rd_sel];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frozen_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         frozen_q  <= frozen_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign bus.ovf     = ovf_all;
   assign bus.frozen  = frozen_q;
   assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrap-mode and a saturate-mode instance (4-bit counters)
// driven in lockstep, checked by a reference model scoreboard and a vector table.
module tb_perf_counter_bank;
   localparam int NCH = 7;
   localparam int CW  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   perf_counter_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) if_w ();
   perf_counter_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) if_s ();

   perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(0)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (if_w)
   );

   perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(1)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (if_s)
   );

   typedef struct {
      logic [CW-1:0]  rd_w;
      logic [CW-1:0]  rd_s;
      logic [NCH-1:0] ovf_w;
      logic [NCH-1:0] ovf_s;
      logic           frz;
   } exp_t;

   typedef struct {
      int             n;
      logic [NCH-1:0] en;
      logic [NCH-1:0] ev;
      logic           clr;
      logic           hlt;
      logic           snp;
      logic [2:0]     sel;
      logic           shd;
      logic [CW-1:0]  exp_w;
      logic [CW-1:0]  exp_s;
      logic [NCH-1:0] exp_ovf_w;
      logic [NCH-1:0] exp_ovf_s;
      logic           exp_frz;
   } vec_t;

   exp_t sb_q [$];
   vec_t vt [$];

   // Reference model: index 0 = wrap instance, 1 = saturate instance.
   logic [CW-1:0]  m_cnt [2][NCH];
   logic [CW-1:0]  m_sh  [2][NCH];
   logic [NCH-1:0] m_ovf [2];
   logic           m_frz;

   int n_err    = 0;
   int n_checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            m_cnt[d][c] = '0;
            m_sh[d][c]  = '0;
         end
         m_ovf[d] = '0;
      end
      m_frz = 1'b0;
      sb_q.delete();
   endtask

   task automatic drive(input logic [NCH-1:0] en, input logic [NCH-1:0] ev, input logic clr,
                        input logic hlt, input logic snp, input logic [2:0] sel, input logic shd);
      if_w.ch_en = en;  if_w.evt = ev;  if_w.clear = clr; if_w.halt = hlt;
      if_w.snap = snp;  if_w.rd_sel = sel; if_w.rd_shadow = shd;
      if_s.ch_en = en;  if_s.evt = ev;  if_s.clear = clr; if_s.halt = hlt;
      if_s.snap = snp;  if_s.rd_sel = sel; if_s.rd_shadow = shd;
   endtask

   // One clock: drive at negedge, predict, then compare just after the posedge.
   task automatic step(input logic [NCH-1:0] en, input logic [NCH-1:0] ev, input logic clr,
                       input logic hlt, input logic snp, input logic [2:0] sel, input logic shd);
      exp_t          e;
      exp_t          got;
      logic [CW-1:0] rd [2];
      @(negedge clk);
      drive(en, ev, clr, hlt, snp, sel, shd);
      for (int d = 0; d < 2; d++) begin
         rd[d] = '0;
         if (int'(sel) < NCH) rd[d] = shd ? m_sh[d][sel] : m_cnt[d][sel];
         for (int c = 0; c < NCH; c++) begin
            if (snp) m_sh[d][c] = m_cnt[d][c];
            if (clr) begin
               m_cnt[d][c] = '0;
               m_ovf[d][c] = 1'b0;
            end else if (ev[c] && en[c] && !m_frz) begin
               if (m_cnt[d][c] == 4'hF) begin
                  m_ovf[d][c] = 1'b1;
                  m_cnt[d][c] = (d == 1) ? 4'hF : 4'h0;
               end else begin
                  m_cnt[d][c] = m_cnt[d][c] + 4'd1;
               end
            end
         end
      end
      if (clr) m_frz = 1'b0;
      else if (hlt) m_frz = 1'b1;
      e.rd_w  = rd[0];
      e.rd_s  = rd[1];
      e.ovf_w = m_ovf[0];
      e.ovf_s = m_ovf[1];
      e.frz   = m_frz;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check("sb_rd_wrap",  64'(if_w.rd_data), 64'(got.rd_w));
      check("sb_rd_sat",   64'(if_s.rd_data), 64'(got.rd_s));
      check("sb_ovf_wrap", 64'(if_w.ovf),     64'(got.ovf_w));
      check("sb_ovf_sat",  64'(if_s.ovf),     64'(got.ovf_s));
      check("sb_frozen",   64'({if_w.frozen, if_s.frozen}), 64'({got.frz, got.frz}));
      $display("step t=%0t ev=%h clr=%b hlt=%b snp=%b sel=%0d shd=%b rd_w=%0d rd_s=%0d ovf_w=%h ovf_s=%h frz=%b",
               $time, ev, clr, hlt, snp, sel, shd, if_w.rd_data, if_s.rd_data, if_w.ovf, if_s.ovf, if_w.frozen);
   endtask

   task automatic idle_read(input logic [2:0] sel, input logic shd);
      step(7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, sel, shd);
   endtask

   function automatic vec_t mk(input int n, input logic [NCH-1:0] en, input logic [NCH-1:0] ev,
                               input logic clr, input logic hlt, input logic snp,
                               input logic [2:0] sel, input logic shd,
                               input logic [CW-1:0] ew, input logic [CW-1:0] es,
                               input logic [NCH-1:0] eow, input logic [NCH-1:0] eos,
                               input logic efz);
      vec_t v;
      v.n = n; v.en = en; v.ev = ev; v.clr = clr; v.hlt = hlt; v.snp = snp;
      v.sel = sel; v.shd = shd; v.exp_w = ew; v.exp_s = es;
      v.exp_ovf_w = eow; v.exp_ovf_s = eos; v.exp_frz = efz;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //      n   en      ev      clr   hlt   snp   sel   shd   exp_w  exp_s  ovf_w   ovf_s   frz
      vt.push_back(mk(10, 7'h7F, 7'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd10, 4'd10, 7'h00, 7'h00, 1'b0));
      vt.push_back(mk(17, 7'h7F, 7'h04, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 4'd1,  4'd15, 7'h04, 7'h04, 1'b0));
      vt.push_back(mk(1,  7'h7F, 7'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 4'd0,  4'd0,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(20, 7'h7F, 7'h02, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd4,  4'd15, 7'h02, 7'h02, 1'b0));
      vt.push_back(mk(1,  7'h7F, 7'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0,  4'd0,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(5,  7'h7F, 7'h08, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd5,  4'd5,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(1,  7'h7F, 7'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 4'd6,  4'd6,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(0,  7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 4'd5,  4'd5,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(3,  7'h7F, 7'h08, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd9,  4'd9,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(1,  7'h7F, 7'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 4'd9,  4'd9,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(0,  7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd0,  4'd0,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(6,  7'h5F, 7'h20, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 4'd0,  4'd0,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(6,  7'h7F, 7'h40, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 4'd0,  4'd0,  7'h00, 7'h00, 1'b0));
      vt.push_back(mk(0,  7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 4'd6,  4'd6,  7'h00, 7'h00, 1'b0));

      // Power-on reset: outputs must be zero while rst is low.
      drive(7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      rst = 1'b1;
      #3 rst = 1'b0;
      #1;
      check("rst_rd_wrap", 64'(if_w.rd_data), 64'(0));
      check("rst_rd_sat",  64'(if_s.rd_data), 64'(0));
      check("rst_ovf",     64'({if_w.ovf, if_s.ovf}), 64'(0));
      check("rst_frozen",  64'({if_w.frozen, if_s.frozen}), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();

      for (int i = 0; i < vt.size(); i++) begin
         for (int k = 0; k < vt[i].n; k++)
            step(vt[i].en, vt[i].ev, vt[i].clr, vt[i].hlt, vt[i].snp, vt[i].sel, vt[i].shd);
         idle_read(vt[i].sel, vt[i].shd);
         check($sformatf("vec%0d_rd_wrap", i),  64'(if_w.rd_data), 64'(vt[i].exp_w));
         check($sformatf("vec%0d_rd_sat", i),   64'(if_s.rd_data), 64'(vt[i].exp_s));
         check($sformatf("vec%0d_ovf_wrap", i), 64'(if_w.ovf),     64'(vt[i].exp_ovf_w));
         check($sformatf("vec%0d_ovf_sat", i),  64'(if_s.ovf),     64'(vt[i].exp_ovf_s));
         check($sformatf("vec%0d_frozen", i),   64'(if_w.frozen),  64'(vt[i].exp_frz));
      end

      // Halt pulse at count 7 with event[4] held: count reaches 8, then freezes.
      step(7'h7F, 7'h00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
      for (int k = 0; k < 12; k++)
         step(7'h7F, 7'h10, 1'b0, (k == 7), 1'b0, 3'd4, 1'b0);
      idle_read(3'd4, 1'b0);
      check("halt_cnt4_wrap", 64'(if_w.rd_data), 64'(8));
      check("halt_cnt4_sat",  64'(if_s.rd_data), 64'(8));
      check("halt_frozen",    64'(if_w.frozen),  64'(1));
      step(7'h7F, 7'h10, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
      idle_read(3'd4, 1'b1);
      check("frozen_snap_shadow4", 64'(if_w.rd_data), 64'(8));
      // clear beats halt in the same cycle, then counting resumes from zero.
      step(7'h7F, 7'h00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0);
      check("clr_over_halt_frozen", 64'({if_w.frozen, if_s.frozen}), 64'(0));
      for (int k = 0; k < 3; k++)
         step(7'h7F, 7'h10, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0);
      idle_read(3'd4, 1'b0);
      check("resume_cnt4", 64'(if_w.rd_data), 64'(3));

      // Asynchronous reset in the middle of a run with overflow and frozen set.
      for (int k = 0; k < 17; k++)
         step(7'h7F, 7'h7F, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      step(7'h7F, 7'h7F, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
      check("pre_rst_ovf_wrap", 64'(if_w.ovf), 64'(7'h7F));
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_rd_wrap", 64'(if_w.rd_data), 64'(0));
      check("mid_rst_rd_sat",  64'(if_s.rd_data), 64'(0));
      check("mid_rst_ovf",     64'({if_w.ovf, if_s.ovf}), 64'(0));
      check("mid_rst_frozen",  64'({if_w.frozen, if_s.frozen}), 64'(0));
      model_reset();
      drive(7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle_read(3'd4, 1'b1);
      check("post_rst_shadow4", 64'(if_w.rd_data), 64'(0));
      step(7'h7F, 7'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      idle_read(3'd0, 1'b0);
      check("post_rst_first_count", 64'(if_w.rd_data), 64'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
